// File: rtl/cmos_nvram_arbiter.sv
// CMOS NVRAM arbiter: the game CPU and the HPS save/load engine share one CMOS RAM.
// Optional pause timeout is built only when NVRAM_PAUSE_TIMEOUT_EN is defined.
module cmos_nvram_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clock_12,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic              hps_req,
  input  logic              hps_wr,
  input  logic              hps_rd,
  input  logic [ADDR_W-1:0] hps_addr,
  input  logic [DATA_W-1:0] hps_wdata,
  output logic [DATA_W-1:0] hps_rdata,
  output logic              hps_ack,
  output logic              hps_grant,
  output logic              hps_err,
  output logic              pause_req,
  input  logic              pause_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [1:0] {StIdle, StPauseWait, StHpsOwn, StRelease} state_e;

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic              ack_q, ack_d;
  logic              armed_q, armed_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic own;
  logic accept;
  logic wr_accept;
  logic rd_accept;

  assign own       = (state_q == StHpsOwn);
  // A request is taken only after IDLE has seen hps_req low for a cycle.
  assign accept    = (state_q == StIdle) && hps_req && armed_q;
  assign wr_accept = own && hps_wr && !pend_q;
  assign rd_accept = own && hps_rd && !hps_wr && !pend_q;

`ifdef NVRAM_PAUSE_TIMEOUT_EN
  logic [11:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        timeout;

  assign timeout = (state_q == StPauseWait) && hps_req && !pause_ack && (cnt_q == 12'hFFF);

  always_comb begin
    cnt_d = (state_q == StPauseWait) ? cnt_q + 12'd1 : 12'd0;
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end
    if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      cnt_q <= 12'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign hps_err = err_q;
`else
  assign hps_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pend_d  = rd_accept;
    ack_d   = wr_accept || pend_q;
    rdata_d = pend_q ? ram_dout : rdata_q;
    armed_d = (state_q == StIdle) && !hps_req;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StPauseWait;
        end
      end
      StPauseWait: begin
        if (!hps_req) begin
          state_d = StIdle;
        end else if (pause_ack) begin
          state_d = StHpsOwn;
`ifdef NVRAM_PAUSE_TIMEOUT_EN
        end else if (timeout) begin
          state_d = StIdle;
`endif
        end
      end
      StHpsOwn: begin
        // A read launched this cycle must finish before ownership is dropped.
        if (!hps_req && !rd_accept) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      armed_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      armed_q <= armed_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = 1'b0;
    if (own) begin
      ram_addr = hps_addr;
      ram_din  = hps_wdata;
      ram_we   = wr_accept;
    end else begin
      ram_we   = cpu_cs && cpu_we;
    end
    if (reset) begin
      ram_we = 1'b0;
    end
  end

  assign cpu_dout  = ram_dout;
  assign hps_rdata = rdata_q;
  assign hps_ack   = ack_q;
  assign hps_grant = own;
  assign pause_req = (state_q == StPauseWait) || own;

endmodule

// File: tb/tb_cmos_nvram_arbiter.sv
// Directed bench for cmos_nvram_arbiter with a behavioural synchronous CMOS RAM.
// Timeout checks are compiled in when NVRAM_PAUSE_TIMEOUT_EN is defined.
module tb_cmos_nvram_arbiter;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 4;

  logic              clock_12 = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_cs, cpu_we;
  logic [DATA_W-1:0] cpu_din, cpu_dout;
  logic              hps_req, hps_wr, hps_rd;
  logic [ADDR_W-1:0] hps_addr;
  logic [DATA_W-1:0] hps_wdata, hps_rdata;
  logic              hps_ack, hps_grant, hps_err;
  logic              pause_req, pause_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din, ram_dout;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  always #5 clock_12 = ~clock_12;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    ram_dout = '0;
  end

  always @(posedge clock_12) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  cmos_nvram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock_12 (clock_12),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_cs   (cpu_cs),
    .cpu_we   (cpu_we),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .hps_req  (hps_req),
    .hps_wr   (hps_wr),
    .hps_rd   (hps_rd),
    .hps_addr (hps_addr),
    .hps_wdata(hps_wdata),
    .hps_rdata(hps_rdata),
    .hps_ack  (hps_ack),
    .hps_grant(hps_grant),
    .hps_err  (hps_err),
    .pause_req(pause_req),
    .pause_ack(pause_ack),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  task automatic tick();
    @(posedge clock_12);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = '0; cpu_din = '0;
    hps_req = 1'b0; hps_wr = 1'b0; hps_rd = 1'b0; hps_addr = '0; hps_wdata = '0;
    pause_ack = 1'b0;
    #2;
    checks++;
    if (pause_req !== 1'b0 || hps_grant !== 1'b0 || hps_ack !== 1'b0 || hps_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req=%b grant=%b ack=%b err=%b, want 0000",
               pause_req, hps_grant, hps_ack, hps_err);
    end
    checks++;
    if (hps_rdata !== 4'h0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h ram_we=%b, want 0 0", hps_rdata, ram_we);
    end
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_cpu_path();
    cpu_addr = 10'h3A5; cpu_din = 4'h9; cpu_cs = 1'b1; cpu_we = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 10'h3A5 || ram_din !== 4'h9) begin
      errors++;
      $display("FAIL cpu_mux: got we=%b addr=%h din=%h, want 1 3a5 9", ram_we, ram_addr, ram_din);
    end
    tick();
    cpu_we = 1'b0;
    tick();
    checks++;
    if (cpu_dout !== 4'h9 || pause_req !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read: got dout=%h pause_req=%b, want 9 0", cpu_dout, pause_req);
    end
    cpu_cs = 1'b0;
  endtask

  task automatic test_idle_strobes();
    hps_addr = 10'h030; hps_wdata = 4'hF; hps_wr = 1'b1; hps_rd = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobe_we: got ram_we=%b, want 0", ram_we);
    end
    tick();
    hps_wr = 1'b0; hps_rd = 1'b0;
    tick();
    checks++;
    if (hps_ack !== 1'b0 || mem[10'h030] !== 4'h0) begin
      errors++;
      $display("FAIL idle_strobe_ack: got ack=%b mem=%h, want 0 0", hps_ack, mem[10'h030]);
    end
  endtask

  task automatic test_pause_handshake();
    hps_req = 1'b1;
    tick();
    checks++;
    if (pause_req !== 1'b1 || hps_grant !== 1'b0) begin
      errors++;
      $display("FAIL pause_cycle1: got req=%b grant=%b, want 1 0", pause_req, hps_grant);
    end
    repeat (5) tick();
    checks++;
    if (hps_grant !== 1'b0 || pause_req !== 1'b1) begin
      errors++;
      $display("FAIL pause_wait: got grant=%b req=%b, want 0 1", hps_grant, pause_req);
    end
    pause_ack = 1'b1;
    tick();
    checks++;
    if (hps_grant !== 1'b1 || pause_req !== 1'b1) begin
      errors++;
      $display("FAIL grant_cycle7: got grant=%b req=%b, want 1 1", hps_grant, pause_req);
    end
    cpu_addr = 10'h3A5; cpu_din = 4'h5; cpu_cs = 1'b1; cpu_we = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_blocked: got ram_we=%b, want 0", ram_we);
    end
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0;
    checks++;
    if (mem[10'h3A5] !== 4'h9) begin
      errors++;
      $display("FAIL cpu_blocked_mem: got %h, want 9", mem[10'h3A5]);
    end
  endtask

  task automatic test_hps_write_read();
    hps_addr = 10'h010; hps_wdata = 4'hC; hps_wr = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 10'h010 || ram_din !== 4'hC) begin
      errors++;
      $display("FAIL hps_wr_mux: got we=%b addr=%h din=%h, want 1 010 c", ram_we, ram_addr, ram_din);
    end
    tick();
    hps_wr = 1'b0; hps_rd = 1'b1;
    checks++;
    if (hps_ack !== 1'b1) begin
      errors++;
      $display("FAIL hps_wr_ack: got %b, want 1", hps_ack);
    end
    tick();
    hps_rd = 1'b0;
    checks++;
    if (hps_ack !== 1'b0) begin
      errors++;
      $display("FAIL hps_rd_ack_early: got %b, want 0", hps_ack);
    end
    tick();
    checks++;
    if (hps_ack !== 1'b1 || hps_rdata !== 4'hC) begin
      errors++;
      $display("FAIL hps_rd_data: got ack=%b rdata=%h, want 1 c", hps_ack, hps_rdata);
    end
    tick();
    checks++;
    if (hps_ack !== 1'b0) begin
      errors++;
      $display("FAIL hps_ack_pulse: got %b, want 0", hps_ack);
    end
  endtask

  task automatic test_busy_and_collide();
    hps_addr = 10'h010; hps_rd = 1'b1;
    tick();
    hps_rd = 1'b0; hps_addr = 10'h020; hps_wdata = 4'h7; hps_wr = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL busy_wr_ignored: got ram_we=%b, want 0", ram_we);
    end
    tick();
    hps_wr = 1'b0;
    checks++;
    if (hps_ack !== 1'b1 || hps_rdata !== 4'hC) begin
      errors++;
      $display("FAIL busy_rd_done: got ack=%b rdata=%h, want 1 c", hps_ack, hps_rdata);
    end
    tick();
    checks++;
    if (hps_ack !== 1'b0 || mem[10'h020] !== 4'h0) begin
      errors++;
      $display("FAIL busy_no_extra: got ack=%b mem=%h, want 0 0", hps_ack, mem[10'h020]);
    end
    hps_addr = 10'h011; hps_wdata = 4'h6; hps_wr = 1'b1; hps_rd = 1'b1;
    tick();
    hps_wr = 1'b0; hps_rd = 1'b0;
    checks++;
    if (hps_ack !== 1'b1) begin
      errors++;
      $display("FAIL collide_wr_ack: got %b, want 1", hps_ack);
    end
    tick();
    checks++;
    if (hps_ack !== 1'b0 || hps_rdata !== 4'hC || mem[10'h011] !== 4'h6) begin
      errors++;
      $display("FAIL collide_rd_dropped: got ack=%b rdata=%h mem=%h, want 0 c 6",
               hps_ack, hps_rdata, mem[10'h011]);
    end
  endtask

  task automatic test_release();
    hps_addr = 10'h011; hps_rd = 1'b1;
    tick();
    hps_rd = 1'b0; hps_req = 1'b0;
    checks++;
    if (hps_ack !== 1'b0 || hps_grant !== 1'b1) begin
      errors++;
      $display("FAIL release_hold: got ack=%b grant=%b, want 0 1", hps_ack, hps_grant);
    end
    tick();
    checks++;
    if (hps_ack !== 1'b1 || hps_rdata !== 4'h6 || pause_req !== 1'b0 || hps_grant !== 1'b0) begin
      errors++;
      $display("FAIL release_rd: got ack=%b rdata=%h req=%b grant=%b, want 1 6 0 0",
               hps_ack, hps_rdata, pause_req, hps_grant);
    end
    tick();
    pause_ack = 1'b0;
    checks++;
    if (hps_ack !== 1'b0 || pause_req !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: got ack=%b req=%b, want 0 0", hps_ack, pause_req);
    end
  endtask

  task automatic test_rearm();
    tick();
    hps_req = 1'b1;
    tick();
    checks++;
    if (pause_req !== 1'b1 || hps_err !== 1'b0) begin
      errors++;
      $display("FAIL rearm_accept: got req=%b err=%b, want 1 0", pause_req, hps_err);
    end
    hps_req = 1'b0;
    tick();
    checks++;
    if (pause_req !== 1'b0) begin
      errors++;
      $display("FAIL pw_abort: got pause_req=%b, want 0", pause_req);
    end
    hps_req = 1'b1;
    tick();
    tick();
    checks++;
    if (pause_req !== 1'b0) begin
      errors++;
      $display("FAIL rearm_block: got pause_req=%b, want 0", pause_req);
    end
    hps_req = 1'b0;
    tick();
    hps_req = 1'b1;
    tick();
    pause_ack = 1'b1;
    checks++;
    if (pause_req !== 1'b1) begin
      errors++;
      $display("FAIL rearm_again: got pause_req=%b, want 1", pause_req);
    end
    tick();
    checks++;
    if (hps_grant !== 1'b1) begin
      errors++;
      $display("FAIL rearm_grant: got grant=%b, want 1", hps_grant);
    end
  endtask

  task automatic test_reset_midread();
    hps_addr = 10'h010; hps_rd = 1'b1;
    tick();
    hps_rd = 1'b0;
    #2;
    reset = 1'b1; hps_req = 1'b0; pause_ack = 1'b0;
    cpu_cs = 1'b1; cpu_we = 1'b1;
    #1;
    checks++;
    if (hps_grant !== 1'b0 || pause_req !== 1'b0 || hps_ack !== 1'b0 ||
        hps_rdata !== 4'h0 || ram_we !== 1'b0 || hps_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_midread: got grant=%b req=%b ack=%b rdata=%h we=%b err=%b, want all 0",
               hps_grant, pause_req, hps_ack, hps_rdata, ram_we, hps_err);
    end
    tick();
    cpu_cs = 1'b0; cpu_we = 1'b0; reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (hps_ack !== 1'b0 || hps_grant !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_ack[%0d]: got ack=%b grant=%b, want 0 0", i, hps_ack, hps_grant);
      end
    end
  endtask

`ifdef NVRAM_PAUSE_TIMEOUT_EN
  task automatic test_timeout();
    hps_req = 1'b1; pause_ack = 1'b0;
    tick();
    repeat (4095) tick();
    checks++;
    if (pause_req !== 1'b1 || hps_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got req=%b err=%b, want 1 0", pause_req, hps_err);
    end
    tick();
    checks++;
    if (pause_req !== 1'b0 || hps_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hit: got req=%b err=%b, want 0 1", pause_req, hps_err);
    end
    hps_req = 1'b0;
    tick();
    checks++;
    if (hps_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b, want 1", hps_err);
    end
    hps_req = 1'b1;
    tick();
    checks++;
    if (hps_err !== 1'b0 || pause_req !== 1'b1) begin
      errors++;
      $display("FAIL err_clear: got err=%b req=%b, want 0 1", hps_err, pause_req);
    end
    hps_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_path();
    test_idle_strobes();
    test_pause_handshake();
    test_hps_write_read();
    test_busy_and_collide();
    test_release();
    test_rearm();
    test_reset_midread();
`ifdef NVRAM_PAUSE_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
